prio_enc_pipe: RTL and testbench
================================

Name: prio_enc_pipe

Overview:
- Parametrised, registered priority encoder; generalises the 8-to-3 encoder to WIDTH request lines.
- Adds a valid/ready handshake on input and output, a registered result, and a selectable round-robin priority mode.
- Sits between request sources (interrupt/arbitration lines) and a consumer that accepts one encoded index per transaction.

Parameters:
- WIDTH, 8, number of request bits in d_in; must be >= 2.
- IDX_W, $clog2(WIDTH), width of the encoded index. This is a derived localparam and is never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  d_in and rr_mode are valid this cycle.
- in_ready  output  1  block can accept an input this cycle.
- d_in  input  WIDTH  request vector.
- rr_mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin priority.
- out_valid  output  1  a_out and none_out hold a result.
- out_ready  input  1  consumer accepts the result this cycle.
- a_out  output  IDX_W  encoded index of the winning request bit.
- none_out  output  1  high when the accepted d_in was all zeros.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, a_out=0, none_out=0.
  - Round-robin pointer ptr=0.
  - Takes effect immediately. Any result in flight is discarded; no partial state survives.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational and does not depend on in_valid.
  - An input is accepted when in_valid && in_ready.
  - The result appears on a_out/none_out with out_valid=1 on the next edge, giving one cycle of latency.
  - Full throughput: a new input is accepted in the same cycle the held result is consumed.
  - While out_valid && !out_ready, outputs are held stable and inputs are not accepted.
  - If nothing is accepted and out_ready=1, out_valid clears on the next edge. a_out and none_out keep their last values.
- Fixed mode (rr_mode=0):
  - a_out = index of the highest set bit of d_in. For WIDTH=8 this is identical to the legacy 8-to-3 mapping.
  - ptr is not modified.
- Round-robin mode (rr_mode=1):
  - Search order starts at index (ptr-1) mod WIDTH and descends, wrapping from 0 to WIDTH-1.
  - The first set bit found wins.
  - On acceptance with a nonzero d_in, ptr <= winning index. The bit granted last therefore becomes lowest priority next time.
  - With ptr=0 (the reset value) the search order equals fixed mode.
- All-zero d_in (either mode): a_out=0, none_out=1, ptr unchanged.
- Nonzero d_in: none_out=0.
- rr_mode is sampled per transaction. Switching modes mid-stream is legal; ptr is retained across fixed-mode transactions.
- A single-bit d_in wins regardless of mode or ptr.

Optional Feature:
- Macro: PRIO_ENC_CNT_EN.
- Defined:
  - Adds output port grant_cnt (16 bits), reset to 0.
  - Increments on each accepted transaction with nonzero d_in.
  - Saturates at 16'hFFFF; does not wrap.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package prio_enc_pkg holds:
  - mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - the counter width constant CNT_W=16.
- One natural sub-module: prio_enc_core. It is a combinational search over WIDTH bits taking a start offset, and returns the index plus a none flag.
  - Fixed mode drives it with start offset WIDTH-1.
  - Round-robin mode drives it with start offset (ptr-1) mod WIDTH.
- The top level contains only the handshake register, ptr and the optional counter.

Test Plan:
- Fixed mode, WIDTH=8, out_ready=1, d_in=8'b0010_1100 -> a_out=5, none_out=0, out_valid one cycle after acceptance.
- d_in=8'h00 in either mode -> a_out=0, none_out=1; ptr unchanged, checked via a following RR request d_in=8'hFF -> a_out=7.
- Round-robin, d_in=8'hFF held for 9 accepted transactions -> a_out sequence 7,6,5,4,3,2,1,0,7.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, a_out stable. Raise out_ready -> new input accepted the same cycle, with no loss and no duplicate.
- Assert rst_n low mid-transaction while out_valid=1 and ptr=3 -> out_valid=0 immediately. After release, RR with d_in=8'hFF gives a_out=7.
- With PRIO_ENC_CNT_EN: 70000 nonzero accepts -> grant_cnt=16'hFFFF. Zero-input accepts do not increment.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// -----------------------------------------------------------------------------
// prio_enc_pkg
// Shared constants for the pipelined priority encoder.
//   MODE_FIXED / MODE_RR : encodings of the rr_mode input.
//   CNT_W                : width of the optional grant counter.
// -----------------------------------------------------------------------------
package prio_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int CNT_W = 16;

endpackage : prio_enc_pkg

// File: rtl/prio_enc_core.sv
// -----------------------------------------------------------------------------
// prio_enc_core
// Combinational priority search over WIDTH request bits. The search begins at
// index 'start' and descends, wrapping from 0 to WIDTH-1; the first set bit
// found wins.
// Ports:
//   req   : request vector
//   start : first index examined (must be < WIDTH)
//   idx   : winning index (0 when no request is set)
//   none  : high when req is all zeros
// -----------------------------------------------------------------------------
module prio_enc_core
    import prio_enc_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             none
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    always_comb begin
        idx     = '0;
        none    = 1'b1;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < WIDTH; k++) begin
            // Descending walk with manual wrap keeps pos inside [0, WIDTH-1]
            // even when WIDTH is not a power of two.
            pos = int'(start) - k;
            if (pos < 0) begin
                pos = pos + WIDTH;
            end
            pos_idx = IDX_W'(pos);
            if (none && req[pos_idx]) begin
                idx  = pos_idx;
                none = 1'b0;
            end
        end
    end

endmodule : prio_enc_core

// File: rtl/prio_enc_pipe.sv
// -----------------------------------------------------------------------------
// prio_enc_pipe
// Registered WIDTH-bit priority encoder with valid/ready handshakes on both
// sides and selectable fixed / round-robin priority. One cycle of latency,
// full throughput.
// Optional feature (macro PRIO_ENC_CNT_EN): adds a saturating 16-bit counter
// of accepted transactions with a nonzero request vector.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : d_in / rr_mode valid
//   in_ready   : block can accept an input this cycle
//   d_in       : request vector
//   rr_mode    : 0 = fixed (highest index wins), 1 = round-robin
//   out_valid  : a_out / none_out hold a result
//   out_ready  : consumer accepts the result
//   a_out      : encoded winning index
//   none_out   : accepted d_in was all zeros
//   grant_cnt  : (PRIO_ENC_CNT_EN only) saturating nonzero-grant count
// -----------------------------------------------------------------------------
module prio_enc_pipe
    import prio_enc_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d_in,
    input  logic             rr_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] a_out,
    output logic             none_out
`ifdef PRIO_ENC_CNT_EN
    ,
    output logic [CNT_W-1:0] grant_cnt
`endif
);

    logic             vld_p1;
    logic [IDX_W-1:0] a_p1;
    logic             none_p1;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] start_sel;
    logic [IDX_W-1:0] core_idx;
    logic             core_none;
    logic             accept;

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;

    // Round-robin starts one below the last grant, so the last winner becomes
    // lowest priority; ptr=0 therefore reproduces fixed priority.
    always_comb begin
        start_sel = IDX_W'(WIDTH - 1);
        if (rr_mode == MODE_RR && rr_ptr != '0) begin
            start_sel = rr_ptr - IDX_W'(1);
        end
    end

    prio_enc_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .req   (d_in),
        .start (start_sel),
        .idx   (core_idx),
        .none  (core_none)
    );

    // ---- stage p1: result register and round-robin pointer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            a_p1    <= '0;
            none_p1 <= 1'b0;
            rr_ptr  <= '0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            a_p1    <= core_idx;
            none_p1 <= core_none;
            if (rr_mode == MODE_RR && !core_none) begin
                rr_ptr <= core_idx;
            end
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign a_out     = a_p1;
    assign none_out  = none_p1;

`ifdef PRIO_ENC_CNT_EN
    logic [CNT_W-1:0] cnt_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1 <= '0;
        end else if (accept && !core_none) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign grant_cnt = cnt_p1;
`endif

endmodule : prio_enc_pipe

// File: tb/tb_prio_enc_pipe.sv
module tb_prio_enc_pipe;
    import prio_enc_pkg::*;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d_in;
    logic             rr_mode;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] a_out;
    logic             none_out;
`ifdef PRIO_ENC_CNT_EN
    logic [CNT_W-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    prio_enc_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d_in      (d_in),
        .rr_mode   (rr_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .none_out  (none_out)
`ifdef PRIO_ENC_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    typedef struct packed {
        logic [IDX_W-1:0] a;
        logic             none;
    } res_t;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             m;
        logic [IDX_W-1:0] a;
        logic             none;
    } vec_t;

    res_t             sb_q[$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [IDX_W-1:0] mdl_ptr;
    logic [IDX_W-1:0] last_a;
    logic             last_none;
    bit               rnd_bp = 1'b0;
    vec_t             tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: fixed = highest set bit; round-robin = set bit i maximising
    // (i - ptr) mod WIDTH, i.e. ptr-1 is best and ptr itself is worst.
    task automatic mdl(input logic [WIDTH-1:0] d, input logic m,
                       output logic [IDX_W-1:0] a, output logic none);
        int best;
        a    = '0;
        none = (d == '0);
        best = -1;
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) begin
                if (!m) begin
                    a = IDX_W'(i);
                end else if (((i - int'(mdl_ptr) + WIDTH) % WIDTH) > best) begin
                    best = (i - int'(mdl_ptr) + WIDTH) % WIDTH;
                    a    = IDX_W'(i);
                end
            end
        end
    endtask

    // Output side of the scoreboard: every held result must match the head of
    // the queue; it is retired on the cycle the consumer takes it.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("a_out", 32'(a_out), 32'(sb_q[0].a));
                chk("none_out", 32'(none_out), 32'(sb_q[0].none));
                if (out_ready) begin
                    last_a    = a_out;
                    last_none = none_out;
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] d, input logic m,
                        input logic [IDX_W-1:0] ea, input logic en);
        int   cyc = 0;
        bit   ok  = 1'b0;
        res_t r;
        in_valid = 1'b1;
        d_in     = d;
        rr_mode  = m;
        while (!ok && cyc < 100) begin
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) begin
                r.a    = ea;
                r.none = en;
                sb_q.push_back(r);
                ok = 1'b1;
                if (m && !en) mdl_ptr = ea;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("valid_cleared", 32'(out_valid), 32'd0);
        chk("a_out_kept", 32'(a_out), 32'(last_a));
        chk("none_out_kept", 32'(none_out), 32'(last_none));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_a_out", 32'(a_out), 32'd0);
        chk("rst_none_out", 32'(none_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PRIO_ENC_CNT_EN
        chk("rst_grant_cnt", 32'(grant_cnt), 32'd0);
`endif
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        mdl_ptr = '0;
        #1;
        reset_check();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] d;
        logic             m;
        logic [IDX_W-1:0] ea;
        logic             en;

        tbl[0]  = '{8'h2C, 1'b0, 3'd5, 1'b0};
        tbl[1]  = '{8'h00, 1'b0, 3'd0, 1'b1};
        tbl[2]  = '{8'h00, 1'b1, 3'd0, 1'b1};
        tbl[3]  = '{8'hFF, 1'b1, 3'd7, 1'b0};
        tbl[4]  = '{8'h01, 1'b0, 3'd0, 1'b0};
        tbl[5]  = '{8'h80, 1'b1, 3'd7, 1'b0};
        tbl[6]  = '{8'h81, 1'b1, 3'd0, 1'b0};
        tbl[7]  = '{8'h81, 1'b1, 3'd7, 1'b0};
        tbl[8]  = '{8'h81, 1'b0, 3'd7, 1'b0};
        tbl[9]  = '{8'h30, 1'b1, 3'd5, 1'b0};
        tbl[10] = '{8'h0F, 1'b0, 3'd3, 1'b0};
        tbl[11] = '{8'h30, 1'b1, 3'd4, 1'b0};
        tbl[12] = '{8'h00, 1'b1, 3'd0, 1'b1};
        tbl[13] = '{8'h30, 1'b1, 3'd5, 1'b0};
        tbl[14] = '{8'h04, 1'b1, 3'd2, 1'b0};
        tbl[15] = '{8'h10, 1'b0, 3'd4, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        d_in      = '0;
        rr_mode   = MODE_FIXED;
        out_ready = 1'b1;
        mdl_ptr   = '0;
        last_a    = '0;
        last_none = 1'b0;
        #1;
        reset_check();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // One-cycle latency on the first fixed-mode request.
        send(8'h2C, MODE_FIXED, 3'd5, 1'b0);
        @(negedge clk);
        chk("latency_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        // Table vectors, streamed back to back.
        foreach (tbl[i]) send(tbl[i].d, tbl[i].m, tbl[i].a, tbl[i].none);
        drain();

        // Round-robin rotation from ptr=0 with all requests set.
        do_reset();
        for (int i = 0; i < 9; i++) send(8'hFF, MODE_RR, IDX_W'(7 - i), 1'b0);
        drain();

        // Backpressure: held result stable, pending input waits, no loss/dup.
        out_ready = 1'b0;
        send(8'h0C, MODE_FIXED, 3'd3, 1'b0);
        in_valid = 1'b1;
        d_in     = 8'h50;
        rr_mode  = MODE_FIXED;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        begin
            res_t r;
            r.a    = 3'd6;
            r.none = 1'b0;
            if (in_ready) sb_q.push_back(r);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Asynchronous reset while a result is held and ptr=3.
        do_reset();
        for (int i = 0; i < 5; i++) send(8'hFF, MODE_RR, IDX_W'(7 - i), 1'b0);
        out_ready = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        mdl_ptr = '0;
        #1;
        reset_check();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(8'hFF, MODE_RR, 3'd7, 1'b0);
        drain();

        // Random mix of modes, zero inputs and consumer stalls.
        rnd_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            d = WIDTH'($urandom);
            if ($urandom_range(0, 7) == 0) d = '0;
            if ($urandom_range(0, 3) == 0) d = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
            m = 1'($urandom_range(0, 1));
            mdl(d, m, ea, en);
            send(d, m, ea, en);
        end
        rnd_bp = 1'b0;
        drain();

`ifdef PRIO_ENC_CNT_EN
        do_reset();
        for (int i = 0; i < 2; i++) send(8'h00, MODE_FIXED, 3'd0, 1'b1);
        drain();
        chk("cnt_zero_accepts", 32'(grant_cnt), 32'd0);
        for (int i = 0; i < 3; i++) send(8'h01, MODE_FIXED, 3'd0, 1'b0);
        drain();
        chk("cnt_three", 32'(grant_cnt), 32'd3);
        for (int i = 0; i < 70000; i++) send(8'h01, MODE_FIXED, 3'd0, 1'b0);
        drain();
        chk("cnt_saturated", 32'(grant_cnt), 32'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_prio_enc_pipe
